// File: rtl/circuit_evaluator.sv
// circuit_evaluator
// Drives every input vector of an evolved combinational circuit under test (CUT).
// For each vector it waits for the CUT to settle, then samples the CUT output
// several times, and scores the result against a host-supplied truth table.
// The match count is the fitness value that the evolution loop reads back.
// A vector whose samples disagree counts as unstable and is never scored as a match.
//
// Ports
//   clk            rising-edge clock for all logic
//   rst            synchronous active-high reset
//   start          begins a sweep; only accepted in IDLE
//   expected       truth table; bit v is the required CUT output for input v
//   cut_in         input vector driven into the CUT
//   cut_out        CUT output, asynchronous to clk
//   busy           high while a sweep is in progress
//   done           one-cycle pulse at the end of a sweep
//   score          count of vectors that are stable and match
//   unstable_count count of vectors whose samples disagree
//   match_vec      bit v set when vector v is stable and matches
//
// state  | meaning
// IDLE   | waiting for start; results from the last sweep are held
// SETTLE | cut_in applied, waiting for the CUT and synchronizer to settle
// SAMPLE | taking SAMPLES consecutive samples of the synchronized output
// EVAL   | scoring the current vector, then advancing to the next one
// DONE   | single-cycle completion pulse
module circuit_evaluator #(
  parameter int NUM_INPUTS    = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLES       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2**NUM_INPUTS-1:0]   expected,
  output logic [NUM_INPUTS-1:0]      cut_in,
  input  logic                       cut_out,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_INPUTS:0]        score,
  output logic [NUM_INPUTS:0]        unstable_count,
  output logic [2**NUM_INPUTS-1:0]   match_vec
);

  localparam int NUM_VECS = 2**NUM_INPUTS;
  localparam int CNT_MAX  = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0]         SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]         SAMPLE_LAST = CW'(SAMPLES - 1);
  localparam logic [NUM_INPUTS-1:0] VEC_LAST    = {NUM_INPUTS{1'b1}};
  localparam logic [NUM_INPUTS:0]   ONE_CNT     = (NUM_INPUTS+1)'(1);

  // Two synchronizer stages plus one cycle of CUT propagation must fit in SETTLE.
  generate
    if (SETTLE_CYCLES < 3) begin : g_bad_settle
      $error("circuit_evaluator: SETTLE_CYCLES must be >= 3");
    end
    if (SAMPLES < 1) begin : g_bad_samples
      $error("circuit_evaluator: SAMPLES must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SAMPLE = 3'd2,
    S_EVAL   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [NUM_INPUTS-1:0]     vec_q, vec_d;
  logic [NUM_VECS-1:0]       exp_q, exp_d;
  logic                      s1_q, s2_q;
  logic                      ref_q, ref_d;
  logic                      diff_q, diff_d;
  logic [NUM_INPUTS:0]       score_q, score_d;
  logic [NUM_INPUTS:0]       unst_q, unst_d;
  logic [NUM_VECS-1:0]       match_q, match_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      exp_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      ref_q   <= 1'b0;
      diff_q  <= 1'b0;
      score_q <= '0;
      unst_q  <= '0;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      exp_q   <= exp_d;
      s1_q    <= cut_out;
      s2_q    <= s1_q;
      ref_q   <= ref_d;
      diff_q  <= diff_d;
      score_q <= score_d;
      unst_q  <= unst_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    exp_d   = exp_q;
    ref_d   = ref_q;
    diff_d  = diff_q;
    score_d = score_q;
    unst_d  = unst_q;
    match_d = match_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d   = expected;
          vec_d   = '0;
          cnt_d   = '0;
          score_d = '0;
          unst_d  = '0;
          match_d = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        // The first sample becomes the reference; later samples only flag disagreement.
        if (cnt_q == '0) begin
          ref_d  = s2_q;
          diff_d = 1'b0;
        end else if (s2_q != ref_q) begin
          diff_d = 1'b1;
        end
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d   = '0;
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EVAL: begin
        if (diff_q) begin
          unst_d = unst_q + ONE_CNT;
        end else if (ref_q == exp_q[vec_q]) begin
          score_d        = score_q + ONE_CNT;
          match_d[vec_q] = 1'b1;
        end
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cut_in         = vec_q;
  assign busy           = (state_q == S_SETTLE) || (state_q == S_SAMPLE) || (state_q == S_EVAL);
  assign done           = (state_q == S_DONE);
  assign score          = score_q;
  assign unstable_count = unst_q;
  assign match_vec      = match_q;

endmodule

// File: tb/tb_circuit_evaluator.sv
module tb_circuit_evaluator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] expected;
  logic [3:0]  cut_in;
  logic        cut_out;
  logic        busy;
  logic        done;
  logic [4:0]  score;
  logic [4:0]  unstable_count;
  logic [15:0] match_vec;

  int errors = 0;
  int checks = 0;

  // CUT model selection: 0 = and of in[3]&in[2], 1 = same but toggling at in==5,
  // 2 = two-cycle output delay, 3 = four-cycle output delay
  int          mode;
  logic        tog;
  logic [3:0]  hist [0:3];

  circuit_evaluator dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .expected       (expected),
    .cut_in         (cut_in),
    .cut_out        (cut_out),
    .busy           (busy),
    .done           (done),
    .score          (score),
    .unstable_count (unstable_count),
    .match_vec      (match_vec)
  );

  always #5 clk = ~clk;

  initial tog = 1'b0;
  always @(posedge clk) begin
    tog     <= ~tog;
    hist[0] <= cut_in;
    hist[1] <= hist[0];
    hist[2] <= hist[1];
    hist[3] <= hist[2];
  end

  always_comb begin
    cut_out = cut_in[3] & cut_in[2];
    case (mode)
      1: if (cut_in == 4'd5) cut_out = tog;
      2: cut_out = hist[1][3] & hist[1][2];
      3: cut_out = hist[3][3] & hist[3][2];
      default: ;
    endcase
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    int          mode;
    logic [15:0] exp_tab;
    int          poke;
    int          e_score;
    int          e_unst;
    int          e_match;
  } vec_t;

  // Caller must be at a negedge; start is raised here and accepted on the next posedge.
  task automatic run_sweep(input string nm, input int md, input logic [15:0] tab, input int poke,
                           input int e_score, input int e_unst, input int e_match);
    int busy_cnt;
    bit seen;
    mode     = md;
    expected = tab;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, ".busy_rise"}, int'(busy), 1);
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i > 0) @(negedge clk);
      if (poke != 0) begin
        if (i == 10) start = 1'b1;
        if (i == 11) start = 1'b0;
        if (i == 50) begin start = 1'b1; expected = ~tab; end
        if (i == 51) start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        if (poke != 0) start = 1'b1;   // start during DONE must be ignored
        break;
      end
      if (busy) busy_cnt++;
    end
    chk({nm, ".done_seen"}, int'(seen), 1);
    chk({nm, ".busy_cycles"}, busy_cnt, 144);
    @(negedge clk);
    start = 1'b0;
    chk({nm, ".done_pulse"}, int'(done), 0);
    chk({nm, ".idle_busy"}, int'(busy), 0);
    chk({nm, ".score"}, int'(score), e_score);
    chk({nm, ".unstable"}, int'(unstable_count), e_unst);
    chk({nm, ".match_vec"}, int'(match_vec), e_match);
  endtask

  vec_t tbl [6];

  initial begin
    bit   found;
    bit   done_hit;

    tbl[0] = '{"and_ok",    0, 16'hF000, 0, 16, 0, 16'hFFFF};
    tbl[1] = '{"and_inv",   0, 16'h0FFF, 0,  0, 0, 16'h0000};
    tbl[2] = '{"toggle5",   1, 16'hF000, 0, 15, 1, 16'hFFDF};
    tbl[3] = '{"delay2",    2, 16'hF000, 0, 16, 0, 16'hFFFF};
    tbl[4] = '{"delay4",    3, 16'hF000, 0, 14, 2, 16'hEFFE};
    tbl[5] = '{"poke",      0, 16'hF000, 1, 16, 0, 16'hFFFF};

    mode     = 0;
    rst      = 1'b1;
    start    = 1'b0;
    expected = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst.cut_in", int'(cut_in), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.score", int'(score), 0);
    chk("rst.unstable", int'(unstable_count), 0);
    chk("rst.match_vec", int'(match_vec), 0);
    rst = 1'b0;
    @(negedge clk);

    // Each sweep starts in the idle cycle right after the previous done.
    for (int k = 0; k < 6; k++) begin
      run_sweep(tbl[k].name, tbl[k].mode, tbl[k].exp_tab, tbl[k].poke,
                tbl[k].e_score, tbl[k].e_unst, tbl[k].e_match);
    end

    // Reset while vector 7 is applied aborts the sweep.
    mode     = 0;
    expected = 16'hF000;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cut_in == 4'd7) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midrst.reach_vec7", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.cut_in", int'(cut_in), 0);
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.done", int'(done), 0);
    chk("midrst.score", int'(score), 0);
    chk("midrst.unstable", int'(unstable_count), 0);
    chk("midrst.match_vec", int'(match_vec), 0);
    done_hit = 1'b0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (done || busy) done_hit = 1'b1;
    end
    chk("midrst.stays_idle", int'(done_hit), 0);
    run_sweep("after_rst", 0, 16'hF000, 0, 16, 0, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/circuit_evaluator.md
# circuit_evaluator

Sequential test harness that sits directly around an evolved combinational circuit under test (CUT): it drives every input vector of the CUT's 4-bit input, waits for the LCELL network to settle, and samples the CUT output several times. It then scores each output bit against a truth table supplied by the host. The resulting match count is the fitness value the evolution loop reads back. Instability in the sampled output (oscillation, slow settling) is counted separately and never scored as a match.

## Interface
Parameters:
- NUM_INPUTS, 4, CUT input width; the sweep covers 2**NUM_INPUTS vectors (16).
- SETTLE_CYCLES, 4, cycles spent in SETTLE per vector; must be >= 3 (elaboration error otherwise).
- SAMPLES, 4, consecutive samples taken per vector; must be >= 1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; accepted only in IDLE.
- expected  in  2**NUM_INPUTS  truth table; bit v = required CUT output for input v.
- cut_in  out  NUM_INPUTS  vector driven into the CUT.
- cut_out  in  1  CUT output; asynchronous to clk.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse at sweep end.
- score  out  NUM_INPUTS+1  number of vectors that are stable and match (0..16).
- unstable_count  out  NUM_INPUTS+1  number of vectors with disagreeing samples.
- match_vec  out  2**NUM_INPUTS  bit v = 1 if vector v is stable and matches.

## Operation
- cut_out passes through a 2-flop synchronizer; all sampling uses the second flop (s2).
- FSM states: IDLE, SETTLE, SAMPLE, EVAL, DONE.
- IDLE: when start=1, the following happen: latch expected into exp_q, cut_in<=0, vec<=0, cnt<=0, and score, unstable_count and match_vec are cleared. Next state is SETTLE.
- SETTLE: cnt increments; when cnt==SETTLE_CYCLES-1, cnt<=0 and the FSM goes to SAMPLE.
- SAMPLE: first cycle stores s2 as ref and clears a diff flag. Each later cycle sets diff if s2!=ref. After SAMPLES cycles the FSM goes to EVAL.
- EVAL, one cycle:
  - if diff: unstable_count++.
  - else if ref==exp_q[vec]: score++ and match_vec[vec]<=1.
  - if vec==2**NUM_INPUTS-1, go to DONE; else vec++, cut_in++, go to SETTLE.
- DONE: done=1 for this cycle only, then IDLE.
- busy = state != IDLE and state != DONE.
- Results are held from DONE until the next accepted start.
- start outside IDLE (including in DONE) is ignored. expected is sampled only at acceptance; changes mid-sweep have no effect.
- Counters cannot overflow: the maximum is 2**NUM_INPUTS, which fits in NUM_INPUTS+1 bits.

## Timing
- Reset: state=IDLE, cut_in=0, busy=0, done=0, score=0, unstable_count=0, match_vec=0, synchronizer flops=0.
- Reset asserted mid-sweep aborts immediately: next cycle shows reset values and done never pulses.
- Per vector: SETTLE_CYCLES + SAMPLES + 1 cycles. With defaults that is 9.
- busy rises in the cycle after the start-accepting edge. It stays high for exactly 2**NUM_INPUTS*(SETTLE_CYCLES+SAMPLES+1) cycles: 144 with defaults.
- done pulses in the cycle immediately after the last busy cycle.
- cut_in changes only on the EVAL->SETTLE edge and at start acceptance. It is stable throughout SETTLE and SAMPLE.
- SETTLE_CYCLES >= 3 guarantees s2 reflects the new cut_in before SAMPLE, given 2 cycles of synchronizer latency plus 1 cycle of CUT propagation.
- The earliest next start is the cycle after done (state IDLE). Back-to-back sweeps are therefore separated by 1 idle cycle.

## Test plan
- CUT model out=in[3]&in[2], expected=16'hF000: score=16, unstable_count=0, match_vec=16'hFFFF, busy high 144 cycles, done is a single pulse.
- Same CUT, expected=16'h0FFF: score=0, unstable_count=0, match_vec=16'h0000.
- CUT correct except out toggles every cycle while cut_in==5, expected=16'hF000: unstable_count=1, score=15, match_vec=16'hFFDF.
- CUT model adds 2-cycle output delay: still score=16. A delay of 4 cycles (> SETTLE_CYCLES-2) produces mismatches on vectors where the output changes, namely vectors 0 and 12.
- Assert rst for 1 cycle while vec==7: all outputs reach reset values next cycle and done stays 0. A following start completes with the full correct result.
- Pulse start at cycles 10 and 50 of a sweep and change expected mid-sweep: neither has any effect. Results match the originally latched table, and a start issued the cycle after done is accepted.
